id_ex_stage: RTL and testbench

//  ID/EX pipeline register with operand forwarding and load-use hazard detection.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/fwd_unit.sv | 39 +++
 rtl/id_ex_stage.sv | 174 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline slice: widths, zero register,
// aluOp encodings, the control bundle and forwarding select codes.
package pipe_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int ZERO_REG = 0;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic regWrite;
        logic memRead;
        logic memWrite;
        logic memToReg;
        logic aluSrc;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select generation for the EX-stage rs/rt sources.
// Only instantiated when FWD_EN is defined.
module fwd_unit #(
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_rt,
    input  logic              i_exmem_regWrite,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic              i_memwb_regWrite,
    input  logic [REG_AW-1:0] i_memwb_rd,
    output logic [1:0]        o_sel_rs,
    output logic [1:0]        o_sel_rt
);
    import pipe_pkg::*;

    // The younger result (EX/MEM) shadows the older one (MEM/WB).
    function automatic logic [1:0] pick(
        input logic [REG_AW-1:0] s,
        input logic              ew,
        input logic [REG_AW-1:0] erd,
        input logic              mw,
        input logic [REG_AW-1:0] mrd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (s != REG_AW'(ZERO_REG) && ew && erd == s)
            sel = FWD_EXMEM;
        else if (s != REG_AW'(ZERO_REG) && mw && mrd == s)
            sel = FWD_MEMWB;
        return sel;
    endfunction

    assign o_sel_rs = pick(i_rs, i_exmem_regWrite, i_exmem_rd,
                           i_memwb_regWrite, i_memwb_rd);
    assign o_sel_rt = pick(i_rt, i_exmem_regWrite, i_exmem_rd,
                           i_memwb_regWrite, i_memwb_rd);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW hazard handling.
// Define FWD_EN for operand forwarding; otherwise dependencies stall.
module id_ex_stage #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [5:0]        id_function_code,
    input  logic [1:0]        id_aluOp,
    input  logic              id_aluSrc,
    input  logic              id_regDst,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    input  logic              id_memWrite,
    input  logic              id_memToReg,
    input  logic              exmem_regWrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regWrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_in1,
    output logic [DATA_W-1:0] ex_in2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [5:0]        ex_function_code,
    output logic [1:0]        ex_aluOp,
    output logic [REG_AW-1:0] ex_write_reg,
    output logic              ex_regWrite,
    output logic              ex_memRead,
    output logic              ex_memWrite,
    output logic              ex_memToReg
);
    import pipe_pkg::*;

    logic              r_valid;
    ctrl_t             r_ctrl;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_write_reg;
    logic [5:0]        r_funct;
    logic [1:0]        r_aluOp;

    ctrl_t             w_id_ctrl;
    logic              w_ex_hit;
    logic              w_hazard;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    assign w_id_ctrl = '{
        regWrite: id_regWrite & id_valid,
        memRead:  id_memRead  & id_valid,
        memWrite: id_memWrite & id_valid,
        memToReg: id_memToReg & id_valid,
        aluSrc:   id_aluSrc
    };

    assign w_ex_hit = (r_write_reg != REG_AW'(ZERO_REG))
                    & ((r_write_reg == id_rs) | (r_write_reg == id_rt));

`ifdef FWD_EN
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [1:0]        w_sel_rs;
    logic [1:0]        w_sel_rt;

    // Only a load in EX cannot be bypassed in time.
    assign w_hazard = id_valid & r_valid & r_ctrl.memRead & w_ex_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs <= '0;
            r_rt <= '0;
        end else if (!flush && !stall && !w_hazard) begin
            r_rs <= id_rs;
            r_rt <= id_rt;
        end
    end

    fwd_unit #(.REG_AW(REG_AW)) u_fwd (
        .i_rs             (r_rs),
        .i_rt             (r_rt),
        .i_exmem_regWrite (exmem_regWrite),
        .i_exmem_rd       (exmem_rd),
        .i_memwb_regWrite (memwb_regWrite),
        .i_memwb_rd       (memwb_rd),
        .o_sel_rs         (w_sel_rs),
        .o_sel_rt         (w_sel_rt)
    );

    function automatic logic [DATA_W-1:0] fmux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf
    );
        logic [DATA_W-1:0] v;
        v = rf;
        if (sel == FWD_EXMEM)
            v = exmem_result;
        else if (sel == FWD_MEMWB)
            v = memwb_result;
        return v;
    endfunction

    assign w_fwd_rs = fmux(w_sel_rs, r_rs_data);
    assign w_fwd_rt = fmux(w_sel_rt, r_rt_data);
`else
    logic w_mem_hit;
    logic w_unused;

    assign w_mem_hit = exmem_regWrite
                     & (exmem_rd != REG_AW'(ZERO_REG))
                     & ((exmem_rd == id_rs) | (exmem_rd == id_rt));

    // Hold ID until the producer reaches WB; the register file bypasses it.
    assign w_hazard = id_valid
                    & ((r_valid & r_ctrl.regWrite & w_ex_hit) | w_mem_hit);

    assign w_fwd_rs = r_rs_data;
    assign w_fwd_rt = r_rt_data;
    assign w_unused = ^{memwb_regWrite, memwb_rd, memwb_result,
                        exmem_result};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_ctrl      <= CTRL_NOP;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_write_reg <= '0;
            r_funct     <= '0;
            r_aluOp     <= '0;
        end else if (flush || (!stall && w_hazard)) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
        end else if (!stall) begin
            r_valid     <= id_valid;
            r_ctrl      <= w_id_ctrl;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_write_reg <= id_regDst ? id_rd : id_rt;
            r_funct     <= id_function_code;
            r_aluOp     <= id_aluOp;
        end
    end

    assign hazard_stall     = w_hazard;
    assign ex_valid         = r_valid;
    assign ex_in1           = w_fwd_rs;
    assign ex_in2           = r_ctrl.aluSrc ? r_imm : w_fwd_rt;
    assign ex_store_data    = w_fwd_rt;
    assign ex_function_code = r_funct;
    assign ex_aluOp         = r_aluOp;
    assign ex_write_reg     = r_write_reg;
    assign ex_regWrite      = r_ctrl.regWrite;
    assign ex_memRead       = r_ctrl.memRead;
    assign ex_memWrite      = r_ctrl.memWrite;
    assign ex_memToReg      = r_ctrl.memToReg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; FWD_EN selects which hazard
// scenarios are exercised.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_function_code;
    logic [1:0]  id_aluOp;
    logic        id_aluSrc, id_regDst, id_regWrite;
    logic        id_memRead, id_memWrite, id_memToReg;
    logic        exmem_regWrite, memwb_regWrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        hazard_stall, ex_valid;
    logic [31:0] ex_in1, ex_in2, ex_store_data;
    logic [5:0]  ex_function_code;
    logic [1:0]  ex_aluOp;
    logic [4:0]  ex_write_reg;
    logic        ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg;

    int vecs = 0;
    int errs = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_function_code(id_function_code), .id_aluOp(id_aluOp),
        .id_aluSrc(id_aluSrc), .id_regDst(id_regDst),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_memWrite(id_memWrite), .id_memToReg(id_memToReg),
        .exmem_regWrite(exmem_regWrite), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_regWrite(memwb_regWrite),
        .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid),
        .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_store_data(ex_store_data),
        .ex_function_code(ex_function_code), .ex_aluOp(ex_aluOp),
        .ex_write_reg(ex_write_reg), .ex_regWrite(ex_regWrite),
        .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_memToReg(ex_memToReg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int v, input int rs, input int rt,
                          input int rd, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [31:0] imm,
                          input int fn, input int op, input int src,
                          input int dst, input int rw, input int mr,
                          input int mw, input int m2r);
        id_valid         = 1'(v);
        id_rs            = 5'(rs);
        id_rt            = 5'(rt);
        id_rd            = 5'(rd);
        id_rs_data       = rsd;
        id_rt_data       = rtd;
        id_imm           = imm;
        id_function_code = 6'(fn);
        id_aluOp         = 2'(op);
        id_aluSrc        = 1'(src);
        id_regDst        = 1'(dst);
        id_regWrite      = 1'(rw);
        id_memRead       = 1'(mr);
        id_memWrite      = 1'(mw);
        id_memToReg      = 1'(m2r);
        #1;
    endtask

    task automatic fwd_in(input int ew, input int erd,
                          input logic [31:0] eres, input int mw,
                          input int mrd, input logic [31:0] mres);
        exmem_regWrite = 1'(ew);
        exmem_rd       = 5'(erd);
        exmem_result   = eres;
        memwb_regWrite = 1'(mw);
        memwb_rd       = 5'(mrd);
        memwb_result   = mres;
        #1;
    endtask

    initial begin
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fwd_in(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(ex_valid), 0);
        check("rst_hazard", 32'(hazard_stall), 0);
        check("rst_regWrite", 32'(ex_regWrite), 0);
        check("rst_write_reg", 32'(ex_write_reg), 0);
        rst_n = 1'b1;
        tick();

        // add $3,$1,$2
        set_id(1, 1, 2, 3, 32'h11, 32'h22, 32'h5, 'h20, 2, 0, 1, 1, 0, 0, 0);
        tick();
        check("add_valid", 32'(ex_valid), 1);
        check("add_in1", ex_in1, 32'h11);
        check("add_in2", ex_in2, 32'h22);
        check("add_store", ex_store_data, 32'h22);
        check("add_wr", 32'(ex_write_reg), 3);
        check("add_funct", 32'(ex_function_code), 'h20);
        check("add_aluOp", 32'(ex_aluOp), 2);
        check("add_regWrite", 32'(ex_regWrite), 1);
        check("add_memRead", 32'(ex_memRead), 0);

        // asynchronous reset in the middle of a cycle
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(ex_valid), 0);
        check("mrst_regWrite", 32'(ex_regWrite), 0);
        check("mrst_in1", ex_in1, 0);
        check("mrst_in2", ex_in2, 0);
        check("mrst_store", ex_store_data, 0);
        check("mrst_wr", 32'(ex_write_reg), 0);
        check("mrst_funct", 32'(ex_function_code), 0);
        check("mrst_aluOp", 32'(ex_aluOp), 0);
        check("mrst_hazard", 32'(hazard_stall), 0);
        rst_n = 1'b1;
        tick();
        check("rel_valid", 32'(ex_valid), 1);
        check("rel_in1", ex_in1, 32'h11);
        check("rel_wr", 32'(ex_write_reg), 3);

        // addi $8,$9,-16
        set_id(1, 9, 8, 0, 32'h100, 32'h999, 32'hFFFF_FFF0, 0, 0,
               1, 0, 1, 0, 0, 0);
        check("addi_hazard", 32'(hazard_stall), 0);
        tick();
        check("addi_in1", ex_in1, 32'h100);
        check("addi_in2", ex_in2, 32'hFFFF_FFF0);
        check("addi_store", ex_store_data, 32'h999);
        check("addi_wr", 32'(ex_write_reg), 8);
        check("addi_aluOp", 32'(ex_aluOp), 0);

        // downstream stall holds the stage for three edges
        stall = 1'b1;
        set_id(1, 11, 10, 0, 32'h300, 32'h400, 32'h4, 0, 0,
               1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_in2", ex_in2, 32'hFFFF_FFF0);
            check("stall_wr", 32'(ex_write_reg), 8);
            check("stall_memWrite", 32'(ex_memWrite), 0);
        end
        stall = 1'b0;
        tick();
        check("sw_memWrite", 32'(ex_memWrite), 1);
        check("sw_regWrite", 32'(ex_regWrite), 0);
        check("sw_in1", ex_in1, 32'h300);
        check("sw_in2", ex_in2, 32'h4);
        check("sw_store", ex_store_data, 32'h400);

        stall = 1'b1;
        flush = 1'b1;
        tick();
        check("flush_valid", 32'(ex_valid), 0);
        check("flush_regWrite", 32'(ex_regWrite), 0);
        check("flush_memWrite", 32'(ex_memWrite), 0);
        stall = 1'b0;
        flush = 1'b0;

        set_id(0, 1, 2, 3, 32'h11, 32'h22, 0, 'h20, 2, 0, 1, 1, 1, 1, 0);
        tick();
        check("idle_valid", 32'(ex_valid), 0);
        check("idle_regWrite", 32'(ex_regWrite), 0);
        check("idle_memRead", 32'(ex_memRead), 0);

`ifdef FWD_EN
        // add $3,$1,$2 then sub $4,$3,$1
        set_id(1, 1, 2, 3, 32'h11, 32'h22, 0, 'h20, 2, 0, 1, 1, 0, 0, 0);
        tick();
        set_id(1, 3, 1, 4, 32'hDEAD, 32'h11, 0, 'h22, 2, 0, 1, 1, 0, 0, 0);
        check("sub_hazard", 32'(hazard_stall), 0);
        tick();
        fwd_in(1, 3, 32'h10, 0, 0, 0);
        check("sub_in1", ex_in1, 32'h10);
        check("sub_in2", ex_in2, 32'h11);
        check("sub_wr", 32'(ex_write_reg), 4);

        // EX/MEM beats MEM/WB; $0 never forwards
        set_id(1, 5, 0, 9, 32'h55, 32'h66, 0, 'h20, 2, 0, 1, 1, 0, 0, 0);
        tick();
        fwd_in(1, 5, 32'hAA, 1, 5, 32'hBB);
        check("prio_in1", ex_in1, 32'hAA);
        check("prio_in2", ex_in2, 32'h66);
        fwd_in(0, 5, 32'hAA, 1, 5, 32'hBB);
        check("memwb_in1", ex_in1, 32'hBB);
        fwd_in(1, 0, 32'hCC, 1, 0, 32'hDD);
        check("zero_in1", ex_in1, 32'h55);
        check("zero_in2", ex_in2, 32'h66);
        fwd_in(0, 0, 0, 0, 0, 0);

        // lw $6,0($1) then add $7,$6,$6
        set_id(1, 1, 6, 0, 32'h40, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1);
        tick();
        check("lw_memRead", 32'(ex_memRead), 1);
        check("lw_wr", 32'(ex_write_reg), 6);
        set_id(1, 6, 6, 7, 32'h1, 32'h1, 0, 'h20, 2, 0, 1, 1, 0, 0, 0);
        check("lu_hazard", 32'(hazard_stall), 1);
        tick();
        fwd_in(1, 6, 32'h40, 0, 0, 0);
        check("lu_bubble_valid", 32'(ex_valid), 0);
        check("lu_bubble_memRead", 32'(ex_memRead), 0);
        check("lu_bubble_regWrite", 32'(ex_regWrite), 0);
        check("lu_hazard_once", 32'(hazard_stall), 0);
        tick();
        fwd_in(0, 0, 0, 1, 6, 32'h1234);
        check("lu_valid", 32'(ex_valid), 1);
        check("lu_in1", ex_in1, 32'h1234);
        check("lu_in2", ex_in2, 32'h1234);
        check("lu_wr", 32'(ex_write_reg), 7);
        check("lu_hazard_clear", 32'(hazard_stall), 0);
`else
        // add $3,$1,$2 then add $4,$3,$1 without forwarding
        set_id(1, 1, 2, 3, 32'h11, 32'h22, 0, 'h20, 2, 0, 1, 1, 0, 0, 0);
        tick();
        set_id(1, 3, 1, 4, 32'hDEAD, 32'h11, 0, 'h20, 2, 0, 1, 1, 0, 0, 0);
        check("dep_hazard_ex", 32'(hazard_stall), 1);
        tick();
        fwd_in(1, 3, 32'h10, 0, 0, 0);
        check("dep_bubble1", 32'(ex_valid), 0);
        check("dep_bubble1_rw", 32'(ex_regWrite), 0);
        check("dep_hazard_mem", 32'(hazard_stall), 1);
        tick();
        fwd_in(0, 0, 0, 1, 3, 32'h10);
        set_id(1, 3, 1, 4, 32'h10, 32'h11, 0, 'h20, 2, 0, 1, 1, 0, 0, 0);
        check("dep_bubble2", 32'(ex_valid), 0);
        check("dep_hazard_clear", 32'(hazard_stall), 0);
        tick();
        check("dep_valid", 32'(ex_valid), 1);
        check("dep_in1", ex_in1, 32'h10);
        check("dep_in2", ex_in2, 32'h11);
        check("dep_wr", 32'(ex_write_reg), 4);

        // writes to $0 never create a dependency
        set_id(1, 1, 2, 0, 32'h11, 32'h22, 0, 'h20, 2, 0, 1, 1, 0, 0, 0);
        fwd_in(0, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 5, 0, 0, 0, 'h20, 2, 0, 1, 1, 0, 0, 0);
        check("zero_hazard", 32'(hazard_stall), 0);

        // rt dependency on EX/MEM alone
        set_id(1, 1, 9, 5, 0, 0, 0, 'h20, 2, 0, 1, 1, 0, 0, 0);
        fwd_in(1, 9, 32'h77, 0, 0, 0);
        check("rt_mem_hazard", 32'(hazard_stall), 1);
        fwd_in(0, 9, 32'h77, 0, 0, 0);
        check("rt_mem_clear", 32'(hazard_stall), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
